truth_table_sweeper: RTL
========================

# truth_table_sweeper

Sequencing controller that characterises one 3-input logic function (the `in1, in2, in3 -> out` gate blocks produced by the compiler flow) by driving all eight input combinations and building its 8-bit truth-table code. It sits between a test/configuration host and a single function instance. Per row, it waits a programmable settle time, takes a majority vote over several output samples, and packs the result. At the end it compares the measured code against an expected code and reports match and per-row mismatches.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles `dut_in` is held before sampling starts; legal range 1..255.
- `SAMPLES`, default 3: output samples per row for majority vote; odd, legal range 1..15.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: sweep request; accepted only in IDLE.
- `abort`, input, 1: cancels a sweep in progress.
- `expected`, input, 8: expected truth-table code; captured when `start` is accepted.
- `dut_in`, output, 3: `{in1, in2, in3}` drive to the function under test.
- `dut_out`, input, 1: function output; synchronous to `clk`.
- `busy`, output, 1: sweep in progress.
- `done`, output, 1: one-cycle pulse when a full sweep completes.
- `measured`, output, 8: truth-table code.
- `match`, output, 1: `measured == expected_q`; valid after `done`.
- `err_rows`, output, 8: `measured ^ expected_q`; valid after `done`.

## Operation
- Code bit mapping: `measured[7-i]` holds the output for `dut_in == i`. Examples:
  - Only row 3'b110 low gives 8'hFD.
  - Only row 3'b000 high gives 8'h80.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- **IDLE**
  - `dut_in = 0`, `busy = 0`.
  - If `start && !abort`: capture `expected_q`; clear `measured`, `match`, `err_rows`; set row = 0, settle counter = 0; go to SETTLE.
  - `start` with `abort` in the same cycle is ignored.
- **SETTLE**
  - `dut_in = row`.
  - Count `SETTLE_CYCLES` cycles, then go to SAMPLE with the ones counter cleared.
- **SAMPLE**
  - Sample `dut_out` once per cycle for `SAMPLES` cycles and count ones.
  - On the last sample cycle, the row bit = 1 iff (ones so far + current sample) > `SAMPLES/2`. Write the bit into `measured[7-row]` on that edge.
  - If row == 7, go to DONE. Otherwise row increments and the FSM goes to SETTLE.
  - Row never wraps past 7.
- **DONE**
  - `done = 1` and `busy = 0` for exactly one cycle.
  - `match` and `err_rows` are registered on entry to DONE, so they are valid in the DONE cycle.
  - Return to IDLE.
  - `measured`, `match` and `err_rows` hold until the next accepted `start` or `reset`.
- **abort** in SETTLE or SAMPLE:
  - Next state is IDLE and `dut_in` returns to 0.
  - No `done`; `match` stays 0.
  - `measured` keeps the bits already written.
  - `abort` in IDLE or DONE has no effect.
- `start` while not in IDLE is ignored and not queued.
- `expected` changes after acceptance have no effect.

## Timing
- Reset values (also on `reset` mid-sweep, which wins over all other inputs): state IDLE, `dut_in = 0`, `busy = 0`, `done = 0`, `measured = 0`, `match = 0`, `err_rows = 0`.
- **Start:** `start` is sampled at edge E0. At E0 the FSM enters SETTLE; `busy = 1` and `dut_in = 0` are visible from E0.
- **Per row:** `SETTLE_CYCLES + SAMPLES` cycles.
- **Sample positions:** `dut_out` is sampled at the edges from `SETTLE_CYCLES+1` to `SETTLE_CYCLES+SAMPLES` after `dut_in` changes.
- **Total:** `done` is high in cycle `8*(SETTLE_CYCLES+SAMPLES)` after E0. With defaults that is cycle 56, so there are 56 busy cycles and then 1 done cycle.
- **Back-to-back:** a new `start` is accepted in the cycle after DONE (IDLE); the earliest restart is 2 cycles after the last sample.
- **Widths:**
  - Settle counter: 8 bits.
  - Sample counter and ones counter: 4 bits each.
  - No overflow is possible within the legal parameter ranges.

## Test plan
- Defaults; behavioural function with 2-cycle output delay, out = 0 only for 3'b110; `expected = 8'hFD` -> `done` pulse at cycle 56; `measured = 8'hFD`, `match = 1`, `err_rows = 0`; `dut_in` steps 0..7, with each value held 7 cycles.
- Same function, `expected = 8'hFE` -> `match = 0`, `err_rows = 8'h03`.
- `SAMPLES = 3`; row 5 output is 1 but glitches to 0 on exactly one of its three sample cycles -> `measured[2] = 1`. With two glitched samples -> `measured[2] = 0`.
- Assert `abort` during row 3 SAMPLE -> IDLE next cycle, `dut_in = 0`, no `done`, `measured[7:5]` hold rows 0..2 and the remaining bits are 0. A subsequent `start` runs a full clean sweep.
- Pulse `start` at cycles 10 and 30 mid-sweep -> ignored; `done` still at cycle 56 only. `start` together with `abort` in IDLE -> stays IDLE.
- Assert `reset` in row 6 -> next cycle all outputs at reset values, state IDLE. `measured = 0` even though rows 0..5 had been written.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Sweeps all eight input rows of a 3-input function, majority-votes its output
// per row and packs the result into an 8-bit truth-table code.
module truth_table_sweeper #(
   parameter int SETTLE_CYCLES = 4,
   parameter int SAMPLES       = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] expected,
   output logic [2:0] dut_in,
   input  logic       dut_out,
   output logic       busy,
   output logic       done,
   output logic [7:0] measured,
   output logic       match,
   output logic [7:0] err_rows
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [3:0] SAMPLE_LAST = 4'(SAMPLES - 1);
   localparam logic [4:0] MAJORITY    = 5'(SAMPLES / 2);

   state_t     state, state_next;
   logic [2:0] row;
   logic [7:0] settle_cnt;
   logic [3:0] sample_cnt;
   logic [3:0] ones_cnt;
   logic [7:0] expected_q;

   logic       settle_end;
   logic       sample_end;
   logic [4:0] ones_total;
   logic       row_bit;
   logic [7:0] row_mask;
   logic [7:0] measured_next;

   // The current sample is folded into the vote so the bit lands on the last sample edge.
   assign settle_end    = (settle_cnt == SETTLE_LAST);
   assign sample_end    = (sample_cnt == SAMPLE_LAST);
   assign ones_total    = {1'b0, ones_cnt} + {4'b0000, dut_out};
   assign row_bit       = (ones_total > MAJORITY);
   assign row_mask      = 8'h80 >> row;
   assign measured_next = row_bit ? (measured | row_mask) : (measured & ~row_mask);

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      dut_in     = 3'd0;
      case (state)
         IDLE: begin
            if (start && !abort) state_next = SETTLE;
         end
         SETTLE: begin
            busy   = 1'b1;
            dut_in = row;
            if (abort)           state_next = IDLE;
            else if (settle_end) state_next = SAMPLE;
         end
         SAMPLE: begin
            busy   = 1'b1;
            dut_in = row;
            if (abort)           state_next = IDLE;
            else if (sample_end) state_next = (row == 3'd7) ? DONE : SETTLE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         row        <= 3'd0;
         settle_cnt <= 8'd0;
         sample_cnt <= 4'd0;
         ones_cnt   <= 4'd0;
         expected_q <= 8'd0;
         measured   <= 8'd0;
         match      <= 1'b0;
         err_rows   <= 8'd0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  expected_q <= expected;
                  measured   <= 8'd0;
                  match      <= 1'b0;
                  err_rows   <= 8'd0;
                  row        <= 3'd0;
                  settle_cnt <= 8'd0;
               end
            end
            SETTLE: begin
               if (!abort) begin
                  settle_cnt <= settle_cnt + 8'd1;
                  if (settle_end) begin
                     sample_cnt <= 4'd0;
                     ones_cnt   <= 4'd0;
                  end
               end
            end
            SAMPLE: begin
               // Abort wins over the last sample, so a half-voted row is never written.
               if (!abort) begin
                  if (sample_end) begin
                     measured <= measured_next;
                     if (row == 3'd7) begin
                        match    <= (measured_next == expected_q);
                        err_rows <= measured_next ^ expected_q;
                     end else begin
                        row        <= row + 3'd1;
                        settle_cnt <= 8'd0;
                     end
                  end else begin
                     sample_cnt <= sample_cnt + 4'd1;
                     ones_cnt   <= ones_cnt + {3'b000, dut_out};
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
